reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of entries (power of two); pointer width 4.
REQ-002 SHALL have clk_in  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_in  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have alloc_valid_in  input  1  the issue stage requests a new entry.
REQ-005 SHALL have alloc_regfile_pos_in  input  5  destination register; 0 means no writeback.
REQ-006 SHALL have alloc_type_in  input  3  instruction type; stored and forwarded opaquely.
REQ-007 SHALL have alloc_ready_out  output  1  an entry can be accepted this cycle.
REQ-008 SHALL have alloc_rob_pos_out  output  4  the tag the allocation this cycle receives (the tail).
REQ-009 SHALL have wb_valid_in, wb_rob_pos_in[3:0], wb_data_in[31:0], wb_jump_in, wb_jump_addr_in[31:0]  inputs  the execution result broadcast.
REQ-010 SHALL have transmit_to_commit  output  1  the head entry is offered to commit.
REQ-011 SHALL have regfile_pos_to_commit[4:0], rob_pos_to_commit[3:0], data_to_commit[31:0], jump_addr_to_commit[31:0], type_to_commit[2:0], jump_to_commit  outputs  the head entry fields.
REQ-012 SHALL have ack_from_commit  input  1  commit accepted the head this cycle.
REQ-013 SHALL have flush_from_commit  input  1  the pipeline flushes on a taken jump.
REQ-014 SHALL have full_out, empty_out  outputs  1 each; count_out  output  5  occupancy 0..16.

Function
REQ-015 Each entry SHALL hold busy, ready, regfile_pos, type, data, jump, jump_addr; head, tail, and count SHALL be registers.
REQ-016 alloc_ready_out SHALL equal !full_out, with full_out = (count==16) and empty_out = (count==0), all from registered state only.
REQ-017 A full buffer SHALL refuse allocation even when a pop happens in the same cycle.
REQ-018 alloc_rob_pos_out SHALL equal tail combinationally.
REQ-019 On alloc_valid_in && !full_out, the entry at tail SHALL be written busy=1, ready=0, data=0, jump=0, jump_addr=0, and tail SHALL increment mod 16.
REQ-020 On wb_valid_in, if the entry at wb_rob_pos_in is busy, the block SHALL set ready=1 and store data, jump, and jump_addr there.
REQ-021 A writeback to a non-busy entry SHALL be ignored.
REQ-022 A writeback SHALL become visible at the commit outputs on the following cycle; there SHALL be no same-cycle bypass.
REQ-023 transmit_to_commit SHALL be 1 iff !empty_out && the head entry is ready; it is combinational from registers.
REQ-024 When transmit_to_commit=1, the *_to_commit outputs SHALL show the head entry, with rob_pos_to_commit = head.
REQ-025 When transmit_to_commit=0, all *_to_commit outputs SHALL be 0.
REQ-026 Pop SHALL occur iff transmit_to_commit && ack_from_commit: the head entry is cleared (busy=0, ready=0) and head increments mod 16.
REQ-027 ack_from_commit while transmit_to_commit=0 SHALL be ignored.
REQ-028 A cycle with both a pop and an allocation SHALL leave count unchanged; pop only SHALL decrement count; allocation only SHALL increment it.
REQ-029 Latency: an entry allocated in cycle N SHALL be written back no earlier than N+1 and offered no earlier than N+2.
REQ-030 Flush SHALL take priority over everything else: on flush_from_commit=1, the next edge clears busy/ready of all entries and sets head=tail=count=0.
REQ-031 In a flush cycle, the block SHALL drop allocation, writeback, and pop, even when ack_from_commit=1.
REQ-032 Head and tail SHALL wrap from 15 to 0 with no loss of entries; with head==tail, full and empty are resolved by count only.

Reset
REQ-033 When rst_in=0, the block SHALL asynchronously clear all entry fields, head, tail, and count, regardless of clk_in.
REQ-034 During reset, outputs SHALL be: alloc_ready_out=1, alloc_rob_pos_out=0, transmit_to_commit=0, all *_to_commit=0, full_out=0, empty_out=1, count_out=0.
REQ-035 A reset asserted mid-operation SHALL discard all in-flight entries.
REQ-036 After rst_in rises, the first rising clock edge SHALL be able to accept an allocation.

Verification
REQ-037 Allocate (reg 5, type 2), then write back tag 0 with data 0x1234 next cycle -> transmit_to_commit=1 one cycle later with regfile_pos=5, data=0x1234, rob_pos=0; ack -> empty_out=1.
REQ-038 Allocate 16 entries -> full_out=1, alloc_ready_out=0, count_out=16; a 17th request with a simultaneous pop is refused, so count_out=15 after the edge.
REQ-039 Write back tags 2, 1, 0 in that order -> commits occur in the order 0, 1, 2, and no entry is offered before its writeback.
REQ-040 Run 40 allocations and commits in steady state -> tags wrap 15 to 0, with count_out never above 16 and data matching per tag.
REQ-041 Offer the head with jump=1 and assert flush_from_commit, ack_from_commit, and alloc_valid_in together -> the next cycle shows count_out=0, empty_out=1, alloc_rob_pos_out=0.
REQ-042 Drive rst_in low between clock edges with 7 entries -> the outputs immediately show the REQ-034 values.

Source files
------------

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order allocation, out-of-order writeback, in-order commit of the head entry.
// Latency: writeback visible at commit outputs one cycle later; alloc-to-offer is at least two cycles.
// Backpressure: alloc_ready_out drops when full (even if a pop coincides); the head waits for ack_from_commit.
module reorder_buffer #(
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_in,
    input  logic             rst_in,

    input  logic             alloc_valid_in,
    input  logic [4:0]       alloc_regfile_pos_in,
    input  logic [2:0]       alloc_type_in,
    output logic             alloc_ready_out,
    output logic [PTR_W-1:0] alloc_rob_pos_out,

    input  logic             wb_valid_in,
    input  logic [PTR_W-1:0] wb_rob_pos_in,
    input  logic [31:0]      wb_data_in,
    input  logic             wb_jump_in,
    input  logic [31:0]      wb_jump_addr_in,

    output logic             transmit_to_commit,
    output logic [4:0]       regfile_pos_to_commit,
    output logic [PTR_W-1:0] rob_pos_to_commit,
    output logic [31:0]      data_to_commit,
    output logic [31:0]      jump_addr_to_commit,
    output logic [2:0]       type_to_commit,
    output logic             jump_to_commit,
    input  logic             ack_from_commit,
    input  logic             flush_from_commit,

    output logic             full_out,
    output logic             empty_out,
    output logic [CNT_W-1:0] count_out
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Per-entry storage
    logic             busy_q      [DEPTH];
    logic             ready_q     [DEPTH];
    logic [4:0]       regpos_q    [DEPTH];
    logic [2:0]       type_q      [DEPTH];
    logic [31:0]      data_q      [DEPTH];
    logic             jump_q      [DEPTH];
    logic [31:0]      jaddr_q     [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic do_alloc, do_pop, do_wb;

    // Status and commit offer, derived only from registered state
    always_comb begin
        full_out           = (count_q == FULL_CNT);
        empty_out          = (count_q == '0);
        alloc_ready_out    = !full_out;
        alloc_rob_pos_out  = tail_q;
        count_out          = count_q;
        transmit_to_commit = !empty_out && ready_q[head_q];

        regfile_pos_to_commit = '0;
        rob_pos_to_commit     = '0;
        data_to_commit        = '0;
        jump_addr_to_commit   = '0;
        type_to_commit        = '0;
        jump_to_commit        = 1'b0;
        if (transmit_to_commit) begin
            regfile_pos_to_commit = regpos_q[head_q];
            rob_pos_to_commit     = head_q;
            data_to_commit        = data_q[head_q];
            jump_addr_to_commit   = jaddr_q[head_q];
            type_to_commit        = type_q[head_q];
            jump_to_commit        = jump_q[head_q];
        end
    end

    // Event decode and pointer/count next state; flush suppresses every other event
    always_comb begin
        do_alloc = alloc_valid_in && !full_out && !flush_from_commit;
        do_pop   = transmit_to_commit && ack_from_commit && !flush_from_commit;
        do_wb    = wb_valid_in && busy_q[wb_rob_pos_in] && !flush_from_commit;

        head_d  = do_pop   ? head_q + PTR_W'(1) : head_q;
        tail_d  = do_alloc ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q;
        if (do_alloc && !do_pop)
            count_d = count_q + CNT_W'(1);
        else if (do_pop && !do_alloc)
            count_d = count_q - CNT_W'(1);

        if (flush_from_commit) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Head, tail and occupancy registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry updates: writeback, then pop clear, then allocation (tail is never busy when alloc is allowed)
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                busy_q[i]   <= 1'b0;
                ready_q[i]  <= 1'b0;
                regpos_q[i] <= '0;
                type_q[i]   <= '0;
                data_q[i]   <= '0;
                jump_q[i]   <= 1'b0;
                jaddr_q[i]  <= '0;
            end
        end else if (flush_from_commit) begin
            for (int i = 0; i < DEPTH; i++) begin
                busy_q[i]  <= 1'b0;
                ready_q[i] <= 1'b0;
            end
        end else begin
            if (do_wb) begin
                ready_q[wb_rob_pos_in] <= 1'b1;
                data_q[wb_rob_pos_in]  <= wb_data_in;
                jump_q[wb_rob_pos_in]  <= wb_jump_in;
                jaddr_q[wb_rob_pos_in] <= wb_jump_addr_in;
            end
            if (do_pop) begin
                busy_q[head_q]  <= 1'b0;
                ready_q[head_q] <= 1'b0;
            end
            if (do_alloc) begin
                busy_q[tail_q]   <= 1'b1;
                ready_q[tail_q]  <= 1'b0;
                regpos_q[tail_q] <= alloc_regfile_pos_in;
                type_q[tail_q]   <= alloc_type_in;
                data_q[tail_q]   <= '0;
                jump_q[tail_q]   <= 1'b0;
                jaddr_q[tail_q]  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: driver issues directed and random stimulus,
// monitor compares DUT outputs on the falling edge against a tag-indexed model
// and an in-order queue of outstanding tags, then advances the model.
module tb_reorder_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        alloc_valid_in;
    logic [4:0]  alloc_regfile_pos_in;
    logic [2:0]  alloc_type_in;
    logic        alloc_ready_out;
    logic [3:0]  alloc_rob_pos_out;
    logic        wb_valid_in;
    logic [3:0]  wb_rob_pos_in;
    logic [31:0] wb_data_in;
    logic        wb_jump_in;
    logic [31:0] wb_jump_addr_in;
    logic        transmit_to_commit;
    logic [4:0]  regfile_pos_to_commit;
    logic [3:0]  rob_pos_to_commit;
    logic [31:0] data_to_commit;
    logic [31:0] jump_addr_to_commit;
    logic [2:0]  type_to_commit;
    logic        jump_to_commit;
    logic        ack_from_commit;
    logic        flush_from_commit;
    logic        full_out;
    logic        empty_out;
    logic [4:0]  count_out;

    reorder_buffer #(.DEPTH(16)) dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .alloc_valid_in       (alloc_valid_in),
        .alloc_regfile_pos_in (alloc_regfile_pos_in),
        .alloc_type_in        (alloc_type_in),
        .alloc_ready_out      (alloc_ready_out),
        .alloc_rob_pos_out    (alloc_rob_pos_out),
        .wb_valid_in          (wb_valid_in),
        .wb_rob_pos_in        (wb_rob_pos_in),
        .wb_data_in           (wb_data_in),
        .wb_jump_in           (wb_jump_in),
        .wb_jump_addr_in      (wb_jump_addr_in),
        .transmit_to_commit   (transmit_to_commit),
        .regfile_pos_to_commit(regfile_pos_to_commit),
        .rob_pos_to_commit    (rob_pos_to_commit),
        .data_to_commit       (data_to_commit),
        .jump_addr_to_commit  (jump_addr_to_commit),
        .type_to_commit       (type_to_commit),
        .jump_to_commit       (jump_to_commit),
        .ack_from_commit      (ack_from_commit),
        .flush_from_commit    (flush_from_commit),
        .full_out             (full_out),
        .empty_out            (empty_out),
        .count_out            (count_out)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;
    int commits = 0;

    // Reference model: outstanding tags in program order plus per-tag contents
    int          exp_q[$];
    int          m_tail;
    bit          m_busy  [16];
    bit          m_ready [16];
    logic [4:0]  m_reg   [16];
    logic [2:0]  m_type  [16];
    logic [31:0] m_data  [16];
    logic        m_jump  [16];
    logic [31:0] m_jaddr [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_tail = 0;
        for (int i = 0; i < 16; i++) begin
            m_busy[i]  = 1'b0;
            m_ready[i] = 1'b0;
        end
    endtask

    int  cnt;
    int  hd;
    int  wt;
    bit  exp_tx;
    bit  pop;

    // Monitor: compare, then advance the model with the inputs that the next edge will sample
    always @(negedge clk_in) begin
        if (!rst_in) model_clear();
        cnt    = exp_q.size();
        exp_tx = 1'b0;
        hd     = 0;
        if (cnt > 0) begin
            hd     = exp_q[0];
            exp_tx = m_ready[hd];
        end
        chk("count", 32'(count_out), 32'(cnt));
        chk("full", 32'(full_out), 32'(cnt == 16));
        chk("empty", 32'(empty_out), 32'(cnt == 0));
        chk("alloc_ready", 32'(alloc_ready_out), 32'(cnt != 16));
        chk("alloc_pos", 32'(alloc_rob_pos_out), 32'(m_tail));
        chk("transmit", 32'(transmit_to_commit), 32'(exp_tx));
        if (exp_tx) begin
            chk("c_rob_pos", 32'(rob_pos_to_commit), 32'(hd));
            chk("c_reg", 32'(regfile_pos_to_commit), 32'(m_reg[hd]));
            chk("c_type", 32'(type_to_commit), 32'(m_type[hd]));
            chk("c_data", data_to_commit, m_data[hd]);
            chk("c_jump", 32'(jump_to_commit), 32'(m_jump[hd]));
            chk("c_jaddr", jump_addr_to_commit, m_jaddr[hd]);
        end else begin
            chk("idle_commit_fields",
                {22'd0, regfile_pos_to_commit, rob_pos_to_commit, type_to_commit, jump_to_commit},
                32'd0);
            chk("idle_data", data_to_commit | jump_addr_to_commit, 32'd0);
        end

        if (rst_in) begin
            if (flush_from_commit) begin
                model_clear();
            end else begin
                pop = exp_tx && ack_from_commit;
                wt  = int'(wb_rob_pos_in);
                if (wb_valid_in && m_busy[wt]) begin
                    m_ready[wt] = 1'b1;
                    m_data[wt]  = wb_data_in;
                    m_jump[wt]  = wb_jump_in;
                    m_jaddr[wt] = wb_jump_addr_in;
                end
                if (pop) begin
                    m_busy[hd]  = 1'b0;
                    m_ready[hd] = 1'b0;
                    void'(exp_q.pop_front());
                    commits++;
                end
                if (alloc_valid_in && cnt < 16) begin
                    m_busy[m_tail]  = 1'b1;
                    m_ready[m_tail] = 1'b0;
                    m_reg[m_tail]   = alloc_regfile_pos_in;
                    m_type[m_tail]  = alloc_type_in;
                    m_data[m_tail]  = 32'd0;
                    m_jump[m_tail]  = 1'b0;
                    m_jaddr[m_tail] = 32'd0;
                    exp_q.push_back(m_tail);
                    m_tail = (m_tail + 1) % 16;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        alloc_valid_in       = 1'b0;
        alloc_regfile_pos_in = 5'd0;
        alloc_type_in        = 3'd0;
        wb_valid_in          = 1'b0;
        wb_rob_pos_in        = 4'd0;
        wb_data_in           = 32'd0;
        wb_jump_in           = 1'b0;
        wb_jump_addr_in      = 32'd0;
        ack_from_commit      = 1'b0;
        flush_from_commit    = 1'b0;
    endtask

    task automatic alloc(input logic [4:0] r, input logic [2:0] t);
        alloc_valid_in       = 1'b1;
        alloc_regfile_pos_in = r;
        alloc_type_in        = t;
    endtask

    task automatic wb(input logic [3:0] tag, input logic [31:0] d, input logic j, input logic [31:0] ja);
        wb_valid_in     = 1'b1;
        wb_rob_pos_in   = tag;
        wb_data_in      = d;
        wb_jump_in      = j;
        wb_jump_addr_in = ja;
    endtask

    task automatic reset_outputs_check(input string tagname);
        chk({tagname, "_ready"}, 32'(alloc_ready_out), 32'd1);
        chk({tagname, "_pos"}, 32'(alloc_rob_pos_out), 32'd0);
        chk({tagname, "_tx"}, 32'(transmit_to_commit), 32'd0);
        chk({tagname, "_cdata"}, data_to_commit | jump_addr_to_commit, 32'd0);
        chk({tagname, "_full"}, 32'(full_out), 32'd0);
        chk({tagname, "_empty"}, 32'(empty_out), 32'd1);
        chk({tagname, "_count"}, 32'(count_out), 32'd0);
    endtask

    initial begin
        rst_in = 1'b0;
        idle();
        #2;
        reset_outputs_check("por");
        cyc();
        cyc();
        rst_in = 1'b1;

        // Single allocate / writeback / commit
        alloc(5'd5, 3'd2);
        cyc();
        idle();
        wb(4'd0, 32'h1234, 1'b0, 32'd0);
        cyc();
        idle();
        cyc();
        chk("basic_tx", 32'(transmit_to_commit), 32'd1);
        chk("basic_data", data_to_commit, 32'h1234);
        chk("basic_reg", 32'(regfile_pos_to_commit), 32'd5);
        ack_from_commit = 1'b1;
        cyc();
        idle();
        chk("basic_empty", 32'(empty_out), 32'd1);

        // Fill to 16, then a 17th request alongside a pop must be refused
        flush_from_commit = 1'b1;
        cyc();
        idle();
        for (int i = 0; i < 16; i++) begin
            alloc(5'(i + 1), 3'(i));
            cyc();
        end
        idle();
        chk("fill_full", 32'(full_out), 32'd1);
        chk("fill_ready", 32'(alloc_ready_out), 32'd0);
        chk("fill_count", 32'(count_out), 32'd16);
        wb(4'd0, 32'hAAAA_0000, 1'b0, 32'd0);
        cyc();
        idle();
        alloc(5'd9, 3'd1);
        ack_from_commit = 1'b1;
        cyc();
        idle();
        chk("full_pop_count", 32'(count_out), 32'd15);

        // Out-of-order writeback, in-order commit
        flush_from_commit = 1'b1;
        cyc();
        idle();
        for (int i = 0; i < 3; i++) begin
            alloc(5'(10 + i), 3'd3);
            cyc();
        end
        idle();
        for (int i = 2; i >= 0; i--) begin
            wb(4'(i), 32'hB000 + 32'(i), 1'b0, 32'd0);
            cyc();
        end
        idle();
        ack_from_commit = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        idle();
        chk("ooo_drained", 32'(count_out), 32'd0);

        // Random traffic with wrap-around
        for (int c = 0; c < 800; c++) begin
            idle();
            if ($urandom_range(0, 99) < 60) alloc(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 99) < 70) begin
                wb_valid_in     = 1'b1;
                wb_data_in      = $urandom;
                wb_jump_in      = 1'($urandom_range(0, 1));
                wb_jump_addr_in = $urandom;
                if (exp_q.size() > 0 && $urandom_range(0, 99) < 85)
                    wb_rob_pos_in = 4'(exp_q[$urandom_range(0, exp_q.size() - 1)]);
                else
                    wb_rob_pos_in = 4'($urandom_range(0, 15));
            end
            ack_from_commit   = ($urandom_range(0, 99) < 60);
            flush_from_commit = ($urandom_range(0, 199) == 0);
            cyc();
        end
        idle();
        chk("enough_commits", 32'(commits >= 40), 32'd1);

        // Flush beats a simultaneous ack and allocation
        flush_from_commit = 1'b1;
        cyc();
        idle();
        alloc(5'd7, 3'd4);
        cyc();
        idle();
        wb(4'd0, 32'hCAFE, 1'b1, 32'h8000_0040);
        cyc();
        idle();
        cyc();
        chk("jump_tx", 32'(jump_to_commit), 32'd1);
        flush_from_commit = 1'b1;
        ack_from_commit   = 1'b1;
        alloc(5'd3, 3'd1);
        cyc();
        idle();
        chk("flush_count", 32'(count_out), 32'd0);
        chk("flush_empty", 32'(empty_out), 32'd1);
        chk("flush_pos", 32'(alloc_rob_pos_out), 32'd0);

        // Asynchronous reset between edges with 7 entries in flight
        for (int i = 0; i < 7; i++) begin
            alloc(5'(i + 1), 3'd2);
            cyc();
        end
        idle();
        wb(4'd0, 32'h55, 1'b0, 32'd0);
        cyc();
        idle();
        chk("pre_rst_count", 32'(count_out), 32'd7);
        #2;
        rst_in = 1'b0;
        #1;
        reset_outputs_check("async_rst");
        cyc();
        cyc();
        rst_in = 1'b1;
        alloc(5'd4, 3'd5);
        cyc();
        idle();
        chk("post_rst_alloc", 32'(count_out), 32'd1);
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
